threshold_event_detector: RTL and testbench

- Downstream consumer of the moving-average stage: takes the signed averaged readout stream and detects threshold-crossing pulses with hysteresis.
- For each qualified pulse, emits a one-cycle event record: start timestamp, peak value and width in samples.
- A programmable holdoff follows each event to suppress retriggering; pulses shorter than a minimum width are discarded as glitches.
- Feeds the event/readout capture logic.

---
 rtl/threshold_event_detector.sv | 167 ++++++++++++++++
 tb/tb_threshold_event_detector.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/threshold_event_detector.sv
// Hysteresis threshold pulse detector emitting one-cycle event records (start, peak, width).
// Optional event counter output enabled by defining THRESHOLD_EVENT_COUNT_EN.
module threshold_event_detector #(
   parameter int DATA_WIDTH      = 22,
   parameter int WIDTH_WIDTH     = 16,
   parameter int TIMESTAMP_WIDTH = 32
) (
   input  logic                               clk,
   input  logic                               rst_active_high,
   input  logic signed [DATA_WIDTH-1:0]       data_in,
   input  logic                               data_valid,
   input  logic                               enable,
   input  logic signed [DATA_WIDTH-1:0]       threshold_high,
   input  logic signed [DATA_WIDTH-1:0]       threshold_low,
   input  logic        [WIDTH_WIDTH-1:0]      holdoff_samples,
   input  logic        [WIDTH_WIDTH-1:0]      min_width,
   output logic                               event_valid,
   output logic        [TIMESTAMP_WIDTH-1:0]  event_timestamp,
   output logic signed [DATA_WIDTH-1:0]       event_peak,
   output logic        [WIDTH_WIDTH-1:0]      event_width,
   output logic        [1:0]                  state_out
`ifdef THRESHOLD_EVENT_COUNT_EN
   ,
   output logic        [TIMESTAMP_WIDTH-1:0]  event_count
`endif
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ARMED   = 2'd1,
      ABOVE   = 2'd2,
      HOLDOFF = 2'd3
   } state_t;

   state_t                              state_q, state_d;
   logic        [TIMESTAMP_WIDTH-1:0]   ts_q, ts_d;
   logic        [TIMESTAMP_WIDTH-1:0]   start_ts_q, start_ts_d;
   logic signed [DATA_WIDTH-1:0]        peak_q, peak_d;
   logic        [WIDTH_WIDTH-1:0]       width_q, width_d;
   logic        [WIDTH_WIDTH-1:0]       hold_q, hold_d;
   logic                                ev_valid_q, ev_valid_d;
   logic        [TIMESTAMP_WIDTH-1:0]   ev_ts_q, ev_ts_d;
   logic signed [DATA_WIDTH-1:0]        ev_peak_q, ev_peak_d;
   logic        [WIDTH_WIDTH-1:0]       ev_width_q, ev_width_d;
`ifdef THRESHOLD_EVENT_COUNT_EN
   logic        [TIMESTAMP_WIDTH-1:0]   cnt_q, cnt_d;
`endif

   always_comb begin
      state_d    = state_q;
      ts_d       = ts_q;
      start_ts_d = start_ts_q;
      peak_d     = peak_q;
      width_d    = width_q;
      hold_d     = hold_q;
      ev_valid_d = 1'b0;
      ev_ts_d    = ev_ts_q;
      ev_peak_d  = ev_peak_q;
      ev_width_d = ev_width_q;
`ifdef THRESHOLD_EVENT_COUNT_EN
      cnt_d      = cnt_q;
`endif

      if (state_q != IDLE && data_valid) begin
         ts_d = ts_q + 1'b1;
      end

      // Disarming wins over everything, including a terminating sample on the same edge.
      if (!enable) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE: begin
               state_d = ARMED;
               ts_d    = '0;
`ifdef THRESHOLD_EVENT_COUNT_EN
               cnt_d   = '0;
`endif
            end
            ARMED: begin
               if (data_valid && data_in >= threshold_high) begin
                  state_d    = ABOVE;
                  start_ts_d = ts_q;
                  width_d    = WIDTH_WIDTH'(1);
                  peak_d     = data_in;
               end
            end
            ABOVE: begin
               if (data_valid) begin
                  if (data_in > threshold_low) begin
                     if (width_q != '1) begin
                        width_d = width_q + 1'b1;
                     end
                     if (data_in > peak_q) begin
                        peak_d = data_in;
                     end
                  end else if (width_q >= min_width) begin
                     ev_valid_d = 1'b1;
                     ev_ts_d    = start_ts_q;
                     ev_peak_d  = peak_q;
                     ev_width_d = width_q;
`ifdef THRESHOLD_EVENT_COUNT_EN
                     cnt_d      = cnt_q + 1'b1;
`endif
                     hold_d     = '0;
                     state_d    = (holdoff_samples != '0) ? HOLDOFF : ARMED;
                  end else begin
                     state_d = ARMED;
                  end
               end
            end
            HOLDOFF: begin
               if (data_valid) begin
                  if (({1'b0, hold_q} + 1'b1) >= {1'b0, holdoff_samples}) begin
                     state_d = ARMED;
                  end else begin
                     hold_d = hold_q + 1'b1;
                  end
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst_active_high) begin
         state_q    <= IDLE;
         ts_q       <= '0;
         start_ts_q <= '0;
         peak_q     <= '0;
         width_q    <= '0;
         hold_q     <= '0;
         ev_valid_q <= 1'b0;
         ev_ts_q    <= '0;
         ev_peak_q  <= '0;
         ev_width_q <= '0;
`ifdef THRESHOLD_EVENT_COUNT_EN
         cnt_q      <= '0;
`endif
      end else begin
         state_q    <= state_d;
         ts_q       <= ts_d;
         start_ts_q <= start_ts_d;
         peak_q     <= peak_d;
         width_q    <= width_d;
         hold_q     <= hold_d;
         ev_valid_q <= ev_valid_d;
         ev_ts_q    <= ev_ts_d;
         ev_peak_q  <= ev_peak_d;
         ev_width_q <= ev_width_d;
`ifdef THRESHOLD_EVENT_COUNT_EN
         cnt_q      <= cnt_d;
`endif
      end
   end

   assign event_valid     = ev_valid_q;
   assign event_timestamp = ev_ts_q;
   assign event_peak      = ev_peak_q;
   assign event_width     = ev_width_q;
   assign state_out       = state_q;
`ifdef THRESHOLD_EVENT_COUNT_EN
   assign event_count     = cnt_q;
`endif

endmodule

// File: tb/tb_threshold_event_detector.sv
// Directed bench for threshold_event_detector; expectations hand-derived from sample indices.
// Covers the optional event counter when THRESHOLD_EVENT_COUNT_EN is defined.
module tb_threshold_event_detector;

   localparam int DW = 22;
   localparam int WW = 16;
   localparam int TW = 32;

   logic                 clk = 1'b0;
   logic                 rst_active_high;
   logic signed [DW-1:0] data_in;
   logic                 data_valid;
   logic                 enable;
   logic signed [DW-1:0] threshold_high;
   logic signed [DW-1:0] threshold_low;
   logic        [WW-1:0] holdoff_samples;
   logic        [WW-1:0] min_width;
   logic                 event_valid;
   logic        [TW-1:0] event_timestamp;
   logic signed [DW-1:0] event_peak;
   logic        [WW-1:0] event_width;
   logic        [1:0]    state_out;
`ifdef THRESHOLD_EVENT_COUNT_EN
   logic        [TW-1:0] event_count;
`endif

   int errors = 0;
   int checks = 0;

   threshold_event_detector #(
      .DATA_WIDTH(DW),
      .WIDTH_WIDTH(WW),
      .TIMESTAMP_WIDTH(TW)
   ) dut (
      .clk(clk),
      .rst_active_high(rst_active_high),
      .data_in(data_in),
      .data_valid(data_valid),
      .enable(enable),
      .threshold_high(threshold_high),
      .threshold_low(threshold_low),
      .holdoff_samples(holdoff_samples),
      .min_width(min_width),
      .event_valid(event_valid),
      .event_timestamp(event_timestamp),
      .event_peak(event_peak),
      .event_width(event_width),
      .state_out(state_out)
`ifdef THRESHOLD_EVENT_COUNT_EN
      ,
      .event_count(event_count)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Present one cycle of input, then sample 1 time unit after the edge.
   task automatic step(input logic dv, input int d);
      data_valid = dv;
      data_in    = DW'(d);
      @(posedge clk);
      #1;
   endtask

   task automatic chk_sv(input string tag, input int st, input logic ev);
      check({tag, ".state"}, 64'(state_out), 64'(st));
      check({tag, ".ev"}, 64'(event_valid), 64'(ev));
   endtask

   task automatic chk_rec(input string tag, input int ts, input int pk, input int w);
      check({tag, ".ts"}, 64'(event_timestamp), 64'(ts));
      check({tag, ".peak"}, 64'(event_peak), 64'(pk));
      check({tag, ".width"}, 64'(event_width), 64'(w));
   endtask

   task automatic chk_cnt(input string tag, input int c);
`ifdef THRESHOLD_EVENT_COUNT_EN
      check({tag, ".count"}, 64'(event_count), 64'(c));
`else
      if (c < 0) $display("unused %s", tag);
`endif
   endtask

   initial begin
      rst_active_high = 1'b1;
      enable          = 1'b0;
      data_valid      = 1'b0;
      data_in         = '0;
      threshold_high  = DW'(100);
      threshold_low   = DW'(50);
      holdoff_samples = WW'(3);
      min_width       = WW'(2);
      step(1'b0, 0);
      step(1'b0, 0);
      chk_sv("reset", 0, 1'b0);
      chk_rec("reset", 0, 0, 0);
      chk_cnt("reset", 0);
      rst_active_high = 1'b0;
      step(1'b0, 0);
      chk_sv("idle_hold", 0, 1'b0);

      // Basic pulse; -200 at index 0 must not trigger under signed compare.
      enable = 1'b1;
      step(1'b0, 0);   chk_sv("arm", 1, 1'b0);
      step(1'b1, -200); chk_sv("b0_neg", 1, 1'b0);
      step(1'b1, 0);   chk_sv("b1", 1, 1'b0);
      step(1'b1, 120); chk_sv("b2", 2, 1'b0);
      step(1'b1, 150); chk_sv("b3", 2, 1'b0);
      step(1'b1, 130); chk_sv("b4", 2, 1'b0);
      step(1'b1, 40);  chk_sv("b5_term", 3, 1'b1);
      chk_rec("basic", 2, 150, 3);
      chk_cnt("basic", 1);
      step(1'b0, 0);   chk_sv("b_strobe_clear", 3, 1'b0);
      chk_rec("basic_hold", 2, 150, 3);
      step(1'b1, 0);   chk_sv("b_ho1", 3, 1'b0);
      step(1'b1, 0);   chk_sv("b_ho2", 3, 1'b0);
      step(1'b1, 0);   chk_sv("b_ho3", 1, 1'b0);

      // Glitch reject: indices 9..12.
      step(1'b1, 0);   chk_sv("g0", 1, 1'b0);
      step(1'b1, 120); chk_sv("g1", 2, 1'b0);
      step(1'b1, 40);  chk_sv("g2", 1, 1'b0);
      step(1'b1, 0);   chk_sv("g3", 1, 1'b0);
      chk_rec("glitch_keep", 2, 150, 3);
      chk_cnt("glitch", 1);

      // Holdoff: pulse at 13,14 terminated at 15; 200s at 16..18 ignored; 19 retriggers.
      step(1'b1, 120); chk_sv("h0", 2, 1'b0);
      step(1'b1, 120); chk_sv("h1", 2, 1'b0);
      step(1'b1, 40);  chk_sv("h2", 3, 1'b1);
      chk_rec("hold_ev1", 13, 120, 2);
      step(1'b1, 200); chk_sv("h3", 3, 1'b0);
      step(1'b1, 200); chk_sv("h4", 3, 1'b0);
      step(1'b1, 200); chk_sv("h5", 1, 1'b0);
      step(1'b1, 200); chk_sv("h6_retrig", 2, 1'b0);
      step(1'b1, 200); chk_sv("h7", 2, 1'b0);
      step(1'b1, 40);  chk_sv("h8", 3, 1'b1);
      chk_rec("hold_ev2", 19, 200, 2);
      chk_cnt("hold", 3);
      step(1'b1, 0); step(1'b1, 0); step(1'b1, 0);
      chk_sv("h_done", 1, 1'b0);

      // Hysteresis with invalid gaps: indices 25..29.
      step(1'b1, 120); chk_sv("y0", 2, 1'b0);
      step(1'b0, 10);  chk_sv("y0g", 2, 1'b0);
      step(1'b1, 70);  chk_sv("y1", 2, 1'b0);
      step(1'b0, 500); chk_sv("y1g", 2, 1'b0);
      step(1'b1, 60);  chk_sv("y2", 2, 1'b0);
      step(1'b0, 0);   chk_sv("y2g", 2, 1'b0);
      step(1'b1, 110); chk_sv("y3", 2, 1'b0);
      step(1'b0, 999); chk_sv("y3g", 2, 1'b0);
      step(1'b1, 40);  chk_sv("y4", 3, 1'b1);
      chk_rec("hyst", 25, 120, 4);
      step(1'b0, 0);   chk_sv("y_gap_ho", 3, 1'b0);
      step(1'b1, 0); step(1'b1, 0); step(1'b1, 0);
      chk_sv("y_done", 1, 1'b0);

      // Abort via enable, then re-enable restarts the timestamp.
      step(1'b1, 120); chk_sv("a0", 2, 1'b0);
      step(1'b1, 130); chk_sv("a1", 2, 1'b0);
      enable = 1'b0;
      step(1'b1, 10);  chk_sv("a_dis", 0, 1'b0);
      chk_rec("abort_keep", 25, 120, 4);
      chk_cnt("abort", 4);
      enable = 1'b1;
      step(1'b0, 0);   chk_sv("a_rearm", 1, 1'b0);
      chk_cnt("rearm", 0);
      step(1'b1, 0);
      step(1'b1, 120);
      step(1'b1, 120);
      step(1'b1, 40);  chk_sv("a_ev", 3, 1'b1);
      chk_rec("restart_ts", 1, 120, 2);
      step(1'b1, 0); step(1'b1, 0); step(1'b1, 0);

      // Abort via reset mid-pulse.
      step(1'b1, 120);
      step(1'b1, 130); chk_sv("r1", 2, 1'b0);
      rst_active_high = 1'b1;
      step(1'b1, 10);  chk_sv("r_rst", 0, 1'b0);
      chk_rec("r_rst", 0, 0, 0);
      rst_active_high = 1'b0;
      step(1'b1, 10);  chk_sv("r_arm", 1, 1'b0);

      // Inverted thresholds, min_width 1, no holdoff: width-1 pulses, straight back to ARMED.
      enable = 1'b0;
      step(1'b0, 0);
      threshold_low   = DW'(150);
      min_width       = WW'(1);
      holdoff_samples = WW'(0);
      enable = 1'b1;
      step(1'b0, 0);   chk_sv("inv_arm", 1, 1'b0);
      step(1'b1, 120); chk_sv("inv0", 2, 1'b0);
      step(1'b1, 120); chk_sv("inv1", 1, 1'b1);
      chk_rec("inv", 0, 120, 1);
      step(1'b1, 100); chk_sv("inv2_edge", 2, 1'b0);
      step(1'b1, 99);  chk_sv("inv3", 1, 1'b1);
      chk_rec("inv_b", 2, 100, 1);
      chk_cnt("inv", 2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
